// File: rtl/pulse_stretcher.sv
// Stretches single-cycle request pulses into fixed-length high windows separated by
// low gaps; extra pulses are queued (or extend the window in retrigger mode).
module pulse_stretcher #(
   parameter int unsigned HOLD_CYCLES = 50,
   parameter int unsigned GAP_CYCLES  = 10,
   parameter int unsigned PEND_W      = 4,
   parameter bit          RETRIGGER   = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pulseIn,
   output logic              levelOut,
   output logic              busy,
   output logic [PEND_W-1:0] pendCount,
   output logic              overflow
);

   localparam int unsigned MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W  = $clog2((MAX_HG > 2) ? MAX_HG : 2);
   localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;
   localparam bit                NO_GAP    = (GAP_CYCLES == 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              level_d, busy_d, ovf_d;
   logic [PEND_W-1:0] pend_d;

   logic retrig_hit, gap_exit, has_pend, dispatch, queue_pulse;

   // A retrigger pulse in HOLD suppresses the end-of-window transition.
   assign retrig_hit  = RETRIGGER && (state == HOLD) && pulseIn;
   assign gap_exit    = (cnt == '0) && ((state == GAP) ||
                        ((state == HOLD) && NO_GAP && !retrig_hit));
   assign has_pend    = (pendCount != '0);
   assign dispatch    = gap_exit && has_pend;
   assign queue_pulse = pulseIn && (state != IDLE) && !gap_exit && !retrig_hit;

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         levelOut  <= 1'b0;
         busy      <= 1'b0;
         pendCount <= '0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         levelOut  <= level_d;
         busy      <= busy_d;
         pendCount <= pend_d;
         overflow  <= ovf_d;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         IDLE: begin
            if (pulseIn) begin
               state_d = HOLD;
               cnt_d   = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (retrig_hit) begin
               cnt_d = HOLD_LOAD;
            end else if (cnt == '0) begin
               if (gap_exit) begin
                  if (has_pend || pulseIn) begin
                     cnt_d = HOLD_LOAD;
                  end else begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end
               end else begin
                  state_d = GAP;
                  cnt_d   = GAP_LOAD;
               end
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt == '0) begin
               if (has_pend || pulseIn) begin
                  state_d = HOLD;
                  cnt_d   = HOLD_LOAD;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Registered-output next values, including the pending queue.
   always_comb begin
      level_d = (state_d == HOLD);
      busy_d  = (state_d != IDLE);
      pend_d  = pendCount;
      ovf_d   = overflow;
      if (gap_exit) begin
         // An exit-edge pulse either cancels the dispatch or is consumed directly.
         if (dispatch && !pulseIn) begin
            pend_d = pendCount - PEND_W'(1);
         end
      end else if (queue_pulse) begin
         if (pendCount == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pendCount + PEND_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: two instances (queue and retrigger mode).
module tb_pulse_stretcher;

   logic       clk;
   logic       reset;
   logic       pulse0, pulse1;
   logic       lvl0, busy0, ovf0;
   logic       lvl1, busy1, ovf1;
   logic [1:0] pend0, pend1;

   typedef struct {
      bit         sel;
      logic [4:0] v;
      string      name;
   } exp_t;

   exp_t  expq[$];
   exp_t  e;
   logic [4:0] act;
   string tag;
   int    errors = 0;
   int    checks = 0;

   pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2), .RETRIGGER(1'b0)) dut0 (
      .clk(clk), .reset(reset), .pulseIn(pulse0),
      .levelOut(lvl0), .busy(busy0), .pendCount(pend0), .overflow(ovf0)
   );

   pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2), .RETRIGGER(1'b1)) dut1 (
      .clk(clk), .reset(reset), .pulseIn(pulse1),
      .levelOut(lvl1), .busy(busy1), .pendCount(pend1), .overflow(ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: outputs after each active edge are compared on the following falling edge.
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         e   = expq.pop_front();
         act = e.sel ? {lvl1, busy1, pend1, ovf1} : {lvl0, busy0, pend0, ovf0};
         checks++;
         if (act !== e.v) begin
            errors++;
            $display("FAIL %s: level/busy/pend/ovf got %b_%b_%b_%b required %b_%b_%b_%b",
                     e.name, act[4], act[3], act[2:1], act[0], e.v[4], e.v[3], e.v[2:1], e.v[0]);
         end
      end
   end

   // Drive one edge's inputs for n edges and queue the expected post-edge outputs.
   task automatic stepn(input int n, input bit sel, input bit rst, input bit p,
                        input bit l, input bit b, input int pd, input bit o);
      logic [1:0] pdv;
      pdv = 2'(pd);
      for (int i = 0; i < n; i++) begin
         reset  = rst;
         pulse0 = sel ? 1'b0 : p;
         pulse1 = sel ? p : 1'b0;
         expq.push_back('{sel, {l, b, pdv, o}, tag});
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset  = 1'b1;
      pulse0 = 1'b0;
      pulse1 = 1'b0;

      tag = "reset";
      stepn(1, 0, 1, 1, 0, 0, 0, 0);
      stepn(1, 0, 1, 0, 0, 0, 0, 0);
      stepn(1, 1, 1, 1, 0, 0, 0, 0);
      stepn(2, 0, 0, 0, 0, 0, 0, 0);
      stepn(1, 1, 0, 0, 0, 0, 0, 0);

      tag = "single";
      stepn(1, 0, 0, 1, 1, 1, 0, 0);
      stepn(3, 0, 0, 0, 1, 1, 0, 0);
      stepn(2, 0, 0, 0, 0, 1, 0, 0);
      stepn(2, 0, 0, 0, 0, 0, 0, 0);

      tag = "queue2";
      stepn(1, 0, 0, 1, 1, 1, 0, 0);
      stepn(1, 0, 0, 1, 1, 1, 1, 0);
      stepn(1, 0, 0, 1, 1, 1, 2, 0);
      stepn(1, 0, 0, 0, 1, 1, 2, 0);
      stepn(2, 0, 0, 0, 0, 1, 2, 0);
      stepn(4, 0, 0, 0, 1, 1, 1, 0);
      stepn(2, 0, 0, 0, 0, 1, 1, 0);
      stepn(4, 0, 0, 0, 1, 1, 0, 0);
      stepn(2, 0, 0, 0, 0, 1, 0, 0);
      stepn(2, 0, 0, 0, 0, 0, 0, 0);

      tag = "saturate";
      stepn(1, 0, 0, 1, 1, 1, 0, 0);
      stepn(1, 0, 0, 1, 1, 1, 1, 0);
      stepn(1, 0, 0, 1, 1, 1, 2, 0);
      stepn(1, 0, 0, 1, 1, 1, 3, 0);
      stepn(2, 0, 0, 1, 0, 1, 3, 1);
      stepn(4, 0, 0, 0, 1, 1, 2, 1);
      stepn(2, 0, 0, 0, 0, 1, 2, 1);
      stepn(4, 0, 0, 0, 1, 1, 1, 1);
      stepn(2, 0, 0, 0, 0, 1, 1, 1);
      stepn(4, 0, 0, 0, 1, 1, 0, 1);
      stepn(2, 0, 0, 0, 0, 1, 0, 1);
      stepn(3, 0, 0, 0, 0, 0, 0, 1);
      tag = "ovf_reset";
      stepn(1, 0, 1, 0, 0, 0, 0, 0);
      stepn(1, 0, 0, 0, 0, 0, 0, 0);

      tag = "retrigger";
      stepn(1, 1, 0, 1, 1, 1, 0, 0);
      stepn(1, 1, 0, 1, 1, 1, 0, 0);
      stepn(3, 1, 0, 0, 1, 1, 0, 0);
      stepn(2, 1, 0, 0, 0, 1, 0, 0);
      stepn(2, 1, 0, 0, 0, 0, 0, 0);

      tag = "retrig_gapq";
      stepn(1, 1, 0, 1, 1, 1, 0, 0);
      stepn(3, 1, 0, 0, 1, 1, 0, 0);
      stepn(1, 1, 0, 0, 0, 1, 0, 0);
      stepn(1, 1, 0, 1, 0, 1, 1, 0);
      stepn(4, 1, 0, 0, 1, 1, 0, 0);
      stepn(2, 1, 0, 0, 0, 1, 0, 0);
      stepn(1, 1, 0, 0, 0, 0, 0, 0);

      tag = "gap_exit_pulse";
      stepn(1, 0, 0, 1, 1, 1, 0, 0);
      stepn(3, 0, 0, 0, 1, 1, 0, 0);
      stepn(2, 0, 0, 0, 0, 1, 0, 0);
      stepn(1, 0, 0, 1, 1, 1, 0, 0);
      stepn(3, 0, 0, 0, 1, 1, 0, 0);
      stepn(2, 0, 0, 0, 0, 1, 0, 0);
      stepn(2, 0, 0, 0, 0, 0, 0, 0);

      tag = "reset_mid_hold";
      stepn(1, 0, 0, 1, 1, 1, 0, 0);
      stepn(1, 0, 0, 1, 1, 1, 1, 0);
      stepn(1, 0, 0, 1, 1, 1, 2, 0);
      stepn(1, 0, 1, 0, 0, 0, 0, 0);
      stepn(14, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 5 && expq.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", expq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle enable pulses (as produced by the push-button one-pulser) back into level windows of fixed, human-visible length. Each pulse becomes one high window of `HOLD_CYCLES` cycles, followed by a low gap of `GAP_CYCLES` cycles. In queue mode, pulses that arrive while a window is in progress are counted and replayed later; in retrigger mode they extend the current window. The block sits between pulse-domain control logic and slow consumers such as LEDs, buzzers or 7-segment blanking.

## Interface
- `HOLD_CYCLES`, 50, length of each high window in clocks; must be >= 1.
- `GAP_CYCLES`, 10, minimum low time between queued windows; may be 0.
- `PEND_W`, 4, width of the pending-pulse counter.
- `RETRIGGER`, 0, 1 = a pulse during HOLD reloads the window; 0 = it is queued.
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `pulseIn`  input  1  request pulse; every cycle it is high counts as one pulse.
- `levelOut`  output  1  stretched level, registered.
- `busy`  output  1  high whenever state != IDLE, registered.
- `pendCount`  output  PEND_W  number of queued pulses, registered.
- `overflow`  output  1  sticky; set when a pulse is dropped.

## Operation
- FSM states: IDLE, HOLD, GAP. A down-counter `cnt` has width clog2(max(HOLD_CYCLES, GAP_CYCLES, 2)).
- Reset state (next edge with `reset`=1): state=IDLE, cnt=0, `levelOut`=0, `busy`=0, `pendCount`=0, `overflow`=0. Reset wins over all other activity, including mid-HOLD; pending pulses are discarded.
- IDLE:
  - `pulseIn`=1: go to HOLD, cnt=HOLD_CYCLES-1, `levelOut`=1.
  - Otherwise stay in IDLE.
- HOLD (`levelOut`=1):
  - Each cycle, cnt decrements.
  - At cnt=0: go to GAP with cnt=GAP_CYCLES-1, `levelOut`=0.
  - If GAP_CYCLES=0, apply the GAP-exit rule immediately instead.
- GAP (`levelOut`=0):
  - Each cycle, cnt decrements.
  - At cnt=0 (GAP exit): if `pendCount`>0 or `pulseIn`=1, go to HOLD with cnt=HOLD_CYCLES-1; otherwise go to IDLE.
- Pulses during HOLD or GAP:
  - RETRIGGER=0: `pendCount` increments.
  - RETRIGGER=1, in HOLD: cnt reloads to HOLD_CYCLES-1; no queueing.
  - RETRIGGER=1, in GAP: the pulse is queued as in RETRIGGER=0.
- Pending arithmetic on the GAP-exit dispatch edge:
  - `pendCount` next = `pendCount` + `pulseIn` - dispatch.
  - dispatch=1 only when `pendCount`>0. A `pulseIn` with `pendCount`=0 is consumed directly.
- Saturation: `pendCount` never exceeds 2^PEND_W-1. An increment that would exceed this is dropped and sets `overflow`=1. A simultaneous dispatch makes room, so that case is not a drop.
- GAP_CYCLES=0 with work pending: HOLD windows chain back-to-back and `levelOut` stays continuously high.
- `overflow` clears only on reset.

## Timing
- `pulseIn` is sampled at edge E0 in IDLE.
  - `levelOut` is high after E0 through E(HOLD_CYCLES-1), i.e. exactly HOLD_CYCLES cycles.
  - `levelOut` goes low after E(HOLD_CYCLES).
  - `busy` is high for HOLD_CYCLES+GAP_CYCLES cycles.
- Latency from `pulseIn` to `levelOut`: 1 clock. There is no combinational path from input to output.
- Queued window start: the first cycle after the GAP exit edge, so windows are separated by exactly GAP_CYCLES low cycles.
- `pendCount` changes on the same edge as the pulse that causes the change.

## Test plan
Parameters for all scenarios: HOLD=4, GAP=2, PEND_W=2.
1. Hold `reset`=1 for 2 edges with `pulseIn` toggling -> all outputs 0 and state IDLE; `levelOut` stays 0 on the first edge after `reset` falls.
2. Single pulse sampled at E0 -> `levelOut`=1 after E0–E3 and 0 after E4; `busy`=1 after E0–E5 and 0 after E6; `pendCount`=0 throughout.
3. RETRIGGER=0, pulses at E1 and E2 (during HOLD) -> `pendCount`=1, then 2.
   - Second window high after E6–E9; third window high after E12–E15.
   - `pendCount` reads 1 after E6 and 0 after E12; idle after E18.
4. RETRIGGER=0, five pulses E1–E5 -> `pendCount` saturates at 3 and `overflow`=1 after E4 (E5 lands on the dispatch-free GAP entry and is also dropped). Exactly four windows total; `overflow` remains 1 until reset.
5. RETRIGGER=1, pulse at E1 -> `levelOut` high after E0–E4 (5 cycles), low after E5; `busy` low after E7; `pendCount` stays 0.
6. Pulse arrives on the GAP exit edge with `pendCount`=0 -> new window starts the next cycle and `pendCount` stays 0. Separately, assert `reset` mid-HOLD with `pendCount`=2 -> all outputs 0 next cycle and no further windows.
